wb_regfile: RTL and testbench



---
 rtl/wb_regfile.sv | 90 +++++++++
 tb/tb_wb_regfile.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback-stage register file (32x32, r0 hardwired to zero) with commit trace and retire counter.
// Optional macro WB_REGFILE_BYPASS_EN forwards the committing wb_data to the read ports in the same cycle.
module wb_regfile #(
  parameter int NREG               = 32,
  parameter int TRACE_DEPTH_UNUSED = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_a3,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [4:0]  trace_a3,
  output logic [31:0] trace_data,
  output logic [31:0] retire_count
);

  generate
    if (NREG != 32) begin : g_bad_nreg
      $error("wb_regfile: NREG must be 32 (address width is fixed at 5)");
    end
    if (TRACE_DEPTH_UNUSED != 0) begin : g_bad_trace_depth
      $error("wb_regfile: TRACE_DEPTH_UNUSED is reserved and must be 0");
    end
  endgenerate

  logic [31:0] regs [NREG];
  logic        wr_en;

  assign wr_en = wb_we && (wb_a3 != 5'd0);

  // r0 never matches wr_en, so it holds its reset value of zero forever
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_en && (wb_a3 == 5'(i))) begin
          regs[i] <= wb_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trace_valid  <= 1'b0;
      trace_pc     <= 32'd0;
      trace_a3     <= 5'd0;
      trace_data   <= 32'd0;
      retire_count <= 32'd0;
    end else begin
      trace_valid <= wr_en;
      if (wr_en) begin
        trace_pc     <= wb_pc;
        trace_a3     <= wb_a3;
        trace_data   <= wb_data;
        retire_count <= retire_count + 32'd1;
      end
    end
  end

`ifdef WB_REGFILE_BYPASS_EN
  // Bypass is gated by reset so reads stay zero while reset is held
  always_comb begin
    rs_data = regs[rs_addr];
    rt_data = regs[rt_addr];
    if (reset && wr_en && (wb_a3 == rs_addr)) begin
      rs_data = wb_data;
    end
    if (reset && wr_en && (wb_a3 == rt_addr)) begin
      rt_data = wb_data;
    end
  end
`else
  always_comb begin
    rs_data = regs[rs_addr];
    rt_data = regs[rt_addr];
  end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic against a behavioural model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_a3;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [4:0]  trace_a3;
  logic [31:0] trace_data;
  logic [31:0] retire_count;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  logic [31:0] mregs [32];
  logic [31:0] mcount;
  logic        mtv;
  logic [31:0] mpc;
  logic [4:0]  ma3;
  logic [31:0] mdata;

  wb_regfile dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_a3(wb_a3), .wb_data(wb_data), .wb_pc(wb_pc),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_a3(trace_a3),
    .trace_data(trace_data), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mcount = 32'd0;
    mtv    = 1'b0;
    mpc    = 32'd0;
    ma3    = 5'd0;
    mdata  = 32'd0;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] addr);
    if (!reset || addr == 5'd0) return 32'd0;
`ifdef WB_REGFILE_BYPASS_EN
    if (wb_we && wb_a3 == addr) return wb_data;
`endif
    return mregs[addr];
  endfunction

  // one rising edge; model follows the commit rules, inputs are held across the edge
  task automatic clock_edge();
    bit eff;
    eff = reset && wb_we && (wb_a3 != 5'd0);
    @(posedge clk);
    if (eff) begin
      mregs[wb_a3] = wb_data;
      mcount = mcount + 32'd1;
      mtv = 1'b1;
      mpc = wb_pc;
      ma3 = wb_a3;
      mdata = wb_data;
    end else if (reset) begin
      mtv = 1'b0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    wb_we = 1'b0; wb_a3 = 5'd0; wb_data = 32'd0; wb_pc = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rs_addr = 5'd0; rt_addr = 5'd0;
    reset = 1'b0;
    model_reset();
    clock_edge();
    clock_edge();
    reset = 1'b1;
    clock_edge();
    for (int i = 1; i < 32; i++) begin
      rs_addr = 5'(i); rt_addr = 5'(31 - i + 1);
      #1;
      checks++;
      if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
        errors++;
        $display("FAIL reset_read r%0d: rs=%h rt=%h required 0", i, rs_data, rt_data);
      end
    end
    checks++;
    if (retire_count !== 32'd0 || trace_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%h tv=%b required 0/0", retire_count, trace_valid);
    end
  endtask

  task automatic test_single_write();
    wb_we = 1'b1; wb_a3 = 5'd8; wb_data = 32'h12345678; wb_pc = 32'h00003000;
    clock_edge();
    idle_inputs();
    rs_addr = 5'd8;
    #1;
    checks++;
    if (trace_valid !== 1'b1 || trace_pc !== 32'h3000 || trace_a3 !== 5'd8 ||
        trace_data !== 32'h12345678 || retire_count !== 32'd1) begin
      errors++;
      $display("FAIL single_trace: tv=%b pc=%h a3=%0d d=%h cnt=%h required 1/3000/8/12345678/1",
               trace_valid, trace_pc, trace_a3, trace_data, retire_count);
    end
    checks++;
    if (rs_data !== 32'h12345678) begin
      errors++;
      $display("FAIL single_read: got %h required 12345678", rs_data);
    end
    clock_edge();
    checks++;
    if (trace_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse_end: tv=%b required 0", trace_valid);
    end
  endtask

  task automatic test_r0_disabled();
    logic [31:0] cnt_before;
    cnt_before = mcount;
    wb_we = 1'b1; wb_a3 = 5'd0; wb_data = 32'hFFFFFFFF; wb_pc = 32'h4000;
    rs_addr = 5'd0; rt_addr = 5'd0;
    #1;
    checks++;
    if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
      errors++;
      $display("FAIL r0_no_bypass: rs=%h rt=%h required 0", rs_data, rt_data);
    end
    clock_edge();
    checks++;
    if (trace_valid !== 1'b0 || retire_count !== cnt_before) begin
      errors++;
      $display("FAIL r0_write_dropped: tv=%b cnt=%h required 0/%h", trace_valid, retire_count, cnt_before);
    end
    wb_we = 1'b0; wb_a3 = 5'd5; wb_data = 32'hDEADBEEF;
    rt_addr = 5'd5;
    clock_edge();
    idle_inputs();
    #1;
    checks++;
    if (rs_data !== 32'd0 || rt_data !== 32'd0 || trace_valid !== 1'b0 || retire_count !== cnt_before) begin
      errors++;
      $display("FAIL disabled_write: r0=%h r5=%h tv=%b cnt=%h required 0/0/0/%h",
               rs_data, rt_data, trace_valid, retire_count, cnt_before);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_pre;
    wb_we = 1'b1; wb_a3 = 5'd3; wb_data = 32'h11; wb_pc = 32'h5000;
    clock_edge();
    wb_data = 32'h22; wb_pc = 32'h5004;
    rs_addr = 5'd3; rt_addr = 5'd3;
`ifdef WB_REGFILE_BYPASS_EN
    exp_pre = 32'h22;
`else
    exp_pre = 32'h11;
`endif
    #1;
    checks++;
    if (rs_data !== exp_pre || rt_data !== exp_pre) begin
      errors++;
      $display("FAIL same_cycle_pre: rs=%h rt=%h required %h", rs_data, rt_data, exp_pre);
    end
    clock_edge();
    idle_inputs();
    #1;
    checks++;
    if (rs_data !== 32'h22 || rt_data !== 32'h22) begin
      errors++;
      $display("FAIL same_cycle_post: rs=%h rt=%h required 22", rs_data, rt_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] base;
    base = mcount;
    for (int i = 1; i <= 4; i++) begin
      wb_we = 1'b1; wb_a3 = 5'(i); wb_data = 32'(i); wb_pc = 32'h6000 + 32'(4 * i);
      clock_edge();
      checks++;
      if (trace_valid !== 1'b1 || trace_a3 !== 5'(i) || trace_data !== 32'(i) ||
          retire_count !== base + 32'(i)) begin
        errors++;
        $display("FAIL b2b_step%0d: tv=%b a3=%0d d=%h cnt=%h required 1/%0d/%h/%h",
                 i, trace_valid, trace_a3, trace_data, retire_count, i, i, base + 32'(i));
      end
    end
    idle_inputs();
    rs_addr = 5'd2; rt_addr = 5'd4;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (trace_valid !== 1'b0 || trace_pc !== 32'd0 || trace_a3 !== 5'd0 || trace_data !== 32'd0 ||
        retire_count !== 32'd0 || rs_data !== 32'd0 || rt_data !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: tv=%b pc=%h a3=%0d d=%h cnt=%h rs=%h rt=%h required all 0",
               trace_valid, trace_pc, trace_a3, trace_data, retire_count, rs_data, rt_data);
    end
    wb_we = 1'b1; wb_a3 = 5'd2; wb_data = 32'hABCD;
    #1;
    checks++;
    if (rs_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_held_bypass: rs=%h required 0", rs_data);
    end
    clock_edge();
    checks++;
    if (rs_data !== 32'd0 || retire_count !== 32'd0 || trace_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_write: rs=%h cnt=%h tv=%b required 0/0/0", rs_data, retire_count, trace_valid);
    end
    idle_inputs();
    reset = 1'b1;
    clock_edge();
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.retire_count = 32'hFFFFFFFF;
    #1;
    release dut.retire_count;
    mcount = 32'hFFFFFFFF;
    wb_we = 1'b1; wb_a3 = 5'd9; wb_data = 32'h99; wb_pc = 32'h7000;
    clock_edge();
    idle_inputs();
    checks++;
    if (retire_count !== 32'd0 || trace_valid !== 1'b1) begin
      errors++;
      $display("FAIL counter_wrap: cnt=%h tv=%b required 00000000/1", retire_count, trace_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      wb_we   = ($urandom_range(0, 3) != 0);
      wb_a3   = 5'($urandom_range(0, 31));
      wb_data = $urandom;
      wb_pc   = $urandom & 32'hFFFF_FFFC;
      rs_addr = 5'($urandom_range(0, 31));
      rt_addr = ($urandom_range(0, 3) == 0) ? rs_addr : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 4) == 0) rs_addr = wb_a3;
      #1;
      checks++;
      if (rs_data !== exp_read(rs_addr) || rt_data !== exp_read(rt_addr)) begin
        errors++;
        $display("FAIL rand_read n=%0d: rs[%0d]=%h rt[%0d]=%h required %h/%h",
                 n, rs_addr, rs_data, rt_addr, rt_data, exp_read(rs_addr), exp_read(rt_addr));
      end
      clock_edge();
      checks++;
      if (trace_valid !== mtv || retire_count !== mcount ||
          (mtv && (trace_pc !== mpc || trace_a3 !== ma3 || trace_data !== mdata))) begin
        errors++;
        $display("FAIL rand_commit n=%0d: tv=%b cnt=%h pc=%h a3=%0d d=%h required %b/%h/%h/%0d/%h",
                 n, trace_valid, retire_count, trace_pc, trace_a3, trace_data, mtv, mcount, mpc, ma3, mdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_r0_disabled();
    test_same_cycle();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
